ci_dispatcher: RTL and testbench

// - Sits between the CPU custom-instruction port and the CI units (profile counters etc.).
// - Decodes ciN and forwards one start pulse plus latched operands to the selected unit.
// - Waits for that unit's done, then returns one registered done/result pair to the CPU.
// - Out-of-range ciN gets an immediate zero response, so the CPU never hangs on a bad opcode.

---
 rtl/ci_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_ci_dispatcher.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ci_dispatcher.sv
// ci_dispatcher: routes one CPU custom-instruction request to one of NUM_CI attached units.
//
// A request in IDLE with an in-range ciN latches opcode/operands, pulses the selected unit's
// start, waits for that unit's done and returns a single registered done/result pair. An
// out-of-range ciN is answered immediately with result 0 and sets the sticky error flag.
// Requests are accepted only in IDLE; anything arriving in another state is dropped.
//
// Optional build macro: CI_DISPATCH_TIMEOUT_EN
//   When defined, a WAIT that lasts TIMEOUT_CYCLES cycles is forced to complete with
//   result 32'hDEADBEEF and error set. When undefined, WAIT holds until the unit responds.
//
// Ports:
//   clock, reset      system clock; synchronous active-high reset
//   start, ciN        CPU request pulse and opcode
//   valueA, valueB    CPU operands
//   done, result      1-cycle completion pulse and its result (0 when done is low)
//   busy              high in every state except IDLE
//   error             sticky: bad opcode or timeout; cleared only by reset
//   unitStart         one-hot 1-cycle start to the selected unit
//   unitN/A/B         latched opcode and operands, stable from ISSUE through RESP
//   unitDone          per-unit done
//   unitResult        per-unit results, unit k at [32k+31:32k]
module ci_dispatcher #(
  parameter int unsigned NUM_CI         = 4,
  parameter logic [7:0]  CI_ID_BASE     = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             ciN,
  input  logic [31:0]            valueA,
  input  logic [31:0]            valueB,
  output logic                   done,
  output logic [31:0]            result,
  output logic                   busy,
  output logic                   error,
  output logic [NUM_CI-1:0]      unitStart,
  output logic [7:0]             unitN,
  output logic [31:0]            unitA,
  output logic [31:0]            unitB,
  input  logic [NUM_CI-1:0]      unitDone,
  input  logic [32*NUM_CI-1:0]   unitResult
);

  localparam int unsigned IdxW   = (NUM_CI > 1) ? $clog2(NUM_CI) : 1;
  localparam logic [7:0]  NumCi8 = 8'(NUM_CI);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            done_q, done_d;
  logic [31:0]     result_q, result_d;
  logic            error_q, error_d;
  logic [7:0]      n_q, n_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;

  logic [7:0]      diff;
  logic            in_range;
  logic            sel_done;
  logic [31:0]     sel_result;

`ifdef CI_DISPATCH_TIMEOUT_EN
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            timeout_hit;
  // This WAIT cycle is the TIMEOUT_CYCLES-th one.
  assign timeout_hit = ({1'b0, wait_cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES);
`endif

  // Unsigned 8-bit wrap makes opcodes below the base fall out of range as well.
  assign diff     = ciN - CI_ID_BASE;
  assign in_range = diff < NumCi8;

  // Only the selected unit's done/result are visible; others are ignored.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    unitStart  = '0;
    for (int k = 0; k < NUM_CI; k++) begin
      if (idx_q == IdxW'(k)) begin
        sel_done     = unitDone[k];
        sel_result   = unitResult[32*k +: 32];
        unitStart[k] = (state_q == StIssue);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    result_d = '0;
    error_d  = error_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
`ifdef CI_DISPATCH_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (in_range) begin
            idx_d   = diff[IdxW-1:0];
            n_d     = ciN;
            a_d     = valueA;
            b_d     = valueB;
            state_d = StIssue;
`ifdef CI_DISPATCH_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = StResp;
          end
        end
      end
      StIssue: begin
        if (sel_done) begin
          done_d   = 1'b1;
          result_d = sel_result;
          state_d  = StResp;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (sel_done) begin
          done_d   = 1'b1;
          result_d = sel_result;
          state_d  = StResp;
        end
`ifdef CI_DISPATCH_TIMEOUT_EN
        else if (timeout_hit) begin
          done_d   = 1'b1;
          result_d = 32'hDEADBEEF;
          error_d  = 1'b1;
          state_d  = StResp;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      error_q  <= 1'b0;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
`ifdef CI_DISPATCH_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      result_q <= result_d;
      error_q  <= error_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifdef CI_DISPATCH_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != StIdle);
  assign error  = error_q;
  assign unitN  = n_q;
  assign unitA  = a_q;
  assign unitB  = b_q;

endmodule

// File: tb/tb_ci_dispatcher.sv
// Directed bench for ci_dispatcher (NUM_CI=4, base 0, TIMEOUT_CYCLES=10).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_ci_dispatcher;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   ciN;
  logic [31:0]  valueA, valueB;
  logic         done, busy, error;
  logic [31:0]  result, unitA, unitB;
  logic [7:0]   unitN;
  logic [3:0]   unitStart, unitDone, done_drv;
  logic [127:0] unitResult;
  logic         tie0;

  int tests  = 0;
  int failed = 0;

  // Unit 0 can be tied to answer in the same cycle as its start.
  assign unitDone   = done_drv | {3'b000, tie0 & unitStart[0]};
  assign unitResult = {32'h33333333, 32'hCAFE0002, 32'hBEEF0001, 32'h00001234};

  ci_dispatcher #(
    .NUM_CI        (4),
    .CI_ID_BASE    (8'h00),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ciN       (ciN),
    .valueA    (valueA),
    .valueB    (valueB),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .error     (error),
    .unitStart (unitStart),
    .unitN     (unitN),
    .unitA     (unitA),
    .unitB     (unitB),
    .unitDone  (unitDone),
    .unitResult(unitResult)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; ciN = 8'h00; valueA = '0; valueB = '0;
    done_drv = '0; tie0 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ustart", 32'(unitStart), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_unitA", unitA, 32'd0);
    chk("rst_unitN", 32'(unitN), 32'd0);

    // T1: same-cycle unit 0
    tie0 = 1'b1; start = 1'b1; ciN = 8'h00; valueA = 32'h11; valueB = 32'h22;
    tick(); start = 1'b0;                                   // cycle 1
    chk("t1_ustart", 32'(unitStart), 32'h1);
    chk("t1_done_c1", 32'(done), 32'd0);
    tick();                                                 // cycle 2
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_result", result, 32'h00001234);
    chk("t1_unitA", unitA, 32'h11);
    chk("t1_unitB", unitB, 32'h22);
    tick();                                                 // cycle 3
    chk("t1_busy_c3", 32'(busy), 32'd0);
    chk("t1_result_c3", result, 32'd0);
    tie0 = 1'b0;

    // T2: unit 2 answers 5 cycles after its start
    start = 1'b1; ciN = 8'h02; valueA = 32'hA2A2A2A2; valueB = 32'hB2B2B2B2;
    tick(); start = 1'b0; valueA = '0; valueB = '0;         // cycle 1
    chk("t2_ustart", 32'(unitStart), 32'h4);
    chk("t2_unitN", 32'(unitN), 32'h2);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk("t2_nodone", 32'(done), 32'd0);
      chk("t2_busy", 32'(busy), 32'd1);
      chk("t2_unitA_hold", unitA, 32'hA2A2A2A2);
    end
    done_drv[2] = 1'b1;                                     // cycle 6
    tick(); done_drv = '0;                                  // cycle 7
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_result", result, 32'hCAFE0002);
    chk("t2_unitA", unitA, 32'hA2A2A2A2);
    chk("t2_unitB", unitB, 32'hB2B2B2B2);
    tick();
    chk("t2_done_c8", 32'(done), 32'd0);

    // T4: cross-talk and overlapping start during WAIT on unit 1
    start = 1'b1; ciN = 8'h01; valueA = 32'h1; valueB = 32'h2;
    tick(); start = 1'b0;                                   // cycle 1
    chk("t4_ustart", 32'(unitStart), 32'h2);
    tick();                                                 // cycle 2 (WAIT)
    done_drv[3] = 1'b1; start = 1'b1; ciN = 8'h00;
    tick(); done_drv = '0; start = 1'b0;                    // cycle 3
    chk("t4_nodone_c3", 32'(done), 32'd0);
    chk("t4_busy_c3", 32'(busy), 32'd1);
    chk("t4_ustart_c3", 32'(unitStart), 32'd0);
    chk("t4_unitN", 32'(unitN), 32'h1);
    tick();                                                 // cycle 4
    chk("t4_nodone_c4", 32'(done), 32'd0);
    done_drv[1] = 1'b1;
    tick(); done_drv = '0;                                  // cycle 5 (RESP)
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_result", result, 32'hBEEF0001);
    start = 1'b1; ciN = 8'h00;                              // start during RESP
    tick(); start = 1'b0;                                   // cycle 6
    chk("t4_done_once", 32'(done), 32'd0);
    chk("t4_resp_start_ignored", 32'(busy), 32'd0);
    tick();
    chk("t4_no_ustart", 32'(unitStart), 32'd0);

    // T3: bad opcode
    start = 1'b1; ciN = 8'h09;
    tick(); start = 1'b0;                                   // cycle 1
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_result", result, 32'd0);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_ustart", 32'(unitStart), 32'd0);
    tick();                                                 // cycle 2
    chk("t3_error_sticky", 32'(error), 32'd1);
    chk("t3_busy_c2", 32'(busy), 32'd0);
    chk("t3_ustart_c2", 32'(unitStart), 32'd0);

    // T5: reset in the middle of a unit 2 wait
    start = 1'b1; ciN = 8'h02; valueA = 32'h55; valueB = 32'h66;
    tick(); start = 1'b0;                                   // cycle 1
    tick(); tick();                                         // cycle 3
    reset = 1'b1;
    tick(); reset = 1'b0;                                   // cycle 4
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_error", 32'(error), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_unitA", unitA, 32'd0);
    tick();
    chk("t5_done_c5", 32'(done), 32'd0);
    tie0 = 1'b1; start = 1'b1; ciN = 8'h00;
    tick(); start = 1'b0;
    chk("t5_ustart", 32'(unitStart), 32'h1);
    tick();
    chk("t5_done_fresh", 32'(done), 32'd1);
    chk("t5_result_fresh", result, 32'h00001234);
    tick();
    chk("t5_busy_after", 32'(busy), 32'd0);
    tie0 = 1'b0;

`ifdef CI_DISPATCH_TIMEOUT_EN
    // T6: unit 3 never responds; forced completion at cycle 12
    start = 1'b1; ciN = 8'h03;
    tick(); start = 1'b0;                                   // cycle 1
    for (int c = 2; c <= 11; c++) begin
      tick();
      chk("t6_nodone", 32'(done), 32'd0);
    end
    tick();                                                 // cycle 12
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_result", result, 32'hDEADBEEF);
    chk("t6_error", 32'(error), 32'd1);
    tick();
    chk("t6_busy_after", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
